// File: rtl/stack_seq.sv
// Stack transfer sequencer: one 16-bit PUSH/POP becomes two byte memory cycles
// with SP inc/dec commands. Optional bounds checking under STACK_SEQ_BOUNDS_EN.
module stack_seq #(
  parameter logic [2:0] SP_SEL_HOLD = 3'd0,
  parameter logic [2:0] SP_SEL_INCR = 3'd1,
  parameter logic [2:0] SP_SEL_DECR = 3'd2
`ifdef STACK_SEQ_BOUNDS_EN
  ,
  parameter logic [15:0] STACK_LOW  = 16'hC000,
  parameter logic [15:0] STACK_HIGH = 16'hFFFE
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_pop,
  input  logic [15:0] req_data,
  output logic        req_ready,
  input  logic [15:0] sp,
  output logic [2:0]  sp_sel,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        stack_fault
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH_HI = 3'd1,
    PUSH_LO = 3'd2,
    POP_LO  = 3'd3,
    POP_HI  = 3'd4
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] data;
  } rsp_t;

  state_t      state, state_nxt;
  logic [15:0] wdata_q;
  logic [7:0]  lo_q;
  rsp_t        rsp_q;
  logic        accept;
  logic        reject;
  logic        take;

  assign accept = req_valid && req_ready;

`ifdef STACK_SEQ_BOUNDS_EN
  logic fault_q;

  // Limits are checked against the SP seen at accept, before any update.
  assign reject = accept && (req_pop ? (sp > (STACK_HIGH - 16'd2))
                                     : (sp < (STACK_LOW + 16'd2)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= reject;
  end

  assign stack_fault = fault_q;
`else
  assign reject      = 1'b0;
  assign stack_fault = 1'b0;
`endif

  assign take = accept && !reject;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take)      state_nxt = req_pop ? POP_LO : PUSH_HI;
      PUSH_HI: if (mem_ready) state_nxt = PUSH_LO;
      PUSH_LO: if (mem_ready) state_nxt = IDLE;
      POP_LO:  if (mem_ready) state_nxt = POP_HI;
      POP_HI:  if (mem_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    sp_sel    = SP_SEL_HOLD;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      IDLE: begin
        // PUSH pre-decrements so the first byte lands at SP-1.
        if (take && !req_pop) sp_sel = SP_SEL_DECR;
      end
      PUSH_HI: begin
        mem_wr    = 1'b1;
        mem_addr  = sp;
        mem_wdata = wdata_q[15:8];
        if (mem_ready) sp_sel = SP_SEL_DECR;
      end
      PUSH_LO: begin
        mem_wr    = 1'b1;
        mem_addr  = sp;
        mem_wdata = wdata_q[7:0];
      end
      POP_LO, POP_HI: begin
        mem_rd   = 1'b1;
        mem_addr = sp;
        if (mem_ready) sp_sel = SP_SEL_INCR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdata_q <= 16'h0000;
      lo_q    <= 8'h00;
      rsp_q   <= '0;
    end else begin
      if (take) wdata_q <= req_data;
      if (state == POP_LO && mem_ready) lo_q <= mem_rdata;
      rsp_q.valid <= mem_ready && (state == PUSH_LO || state == POP_HI);
      if (state == POP_HI && mem_ready) rsp_q.data <= {mem_rdata, lo_q};
    end
  end

  assign rsp_valid = rsp_q.valid;
  assign rsp_data  = rsp_q.data;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: models the SP register and a byte memory.
module tb_stack_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_pop = 1'b0;
  logic [15:0] req_data = 16'h0;
  logic        req_ready;
  logic [15:0] sp;
  logic [2:0]  sp_sel;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd, mem_wr;
  logic        mem_ready = 1'b1;
  logic [7:0]  mem_rdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        stack_fault;

  logic        sp_load = 1'b0;
  logic [15:0] sp_load_val = 16'h0;
  logic [7:0]  mem [0:65535];
  int          wr_cnt = 0;
  int          rdwr_viol = 0;
  int          errors = 0;
  int          checks = 0;

  stack_seq dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_pop(req_pop),
    .req_data(req_data), .req_ready(req_ready), .sp(sp), .sp_sel(sp_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .stack_fault(stack_fault)
  );

  always #5 clock = ~clock;

  // SP block model: sp_sel takes effect on the next rising edge.
  always @(posedge clock) begin
    if (sp_load)             sp <= sp_load_val;
    else if (sp_sel == 3'd1) sp <= sp + 16'd1;
    else if (sp_sel == 3'd2) sp <= sp - 16'd1;
  end

  always @(posedge clock) begin
    if (mem_wr && mem_ready) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_rd && mem_wr) rdwr_viol <= rdwr_viol + 1;
  end

  assign mem_rdata = mem[mem_addr];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load_sp(input logic [15:0] v);
    sp_load = 1'b1; sp_load_val = v;
    tick();
    sp_load = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if ({mem_rd, mem_wr, sp_sel} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0", {mem_rd, mem_wr, sp_sel}); end
    checks++; if ({mem_addr, mem_wdata} !== 24'h0) begin errors++; $display("FAIL reset_addr_data: got %h want 0", {mem_addr, mem_wdata}); end
    checks++; if ({rsp_valid, rsp_data, stack_fault} !== 18'h0) begin errors++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_data, stack_fault}); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_push_basic;
    int w0;
    load_sp(16'hFFFE);
    w0 = wr_cnt;
    mem_ready = 1'b1;
    req_valid = 1'b1; req_pop = 1'b0; req_data = 16'hBEEF;
    #1;
    checks++; if ({req_ready, sp_sel} !== 4'b1_010) begin errors++; $display("FAIL push_accept: got %b want 1010", {req_ready, sp_sel}); end
    tick();
    req_valid = 1'b0;
    checks++; if ({mem_wr, mem_rd, mem_addr, mem_wdata, sp_sel, req_ready} !== {2'b10, 16'hFFFD, 8'hBE, 3'd2, 1'b0}) begin
      errors++; $display("FAIL push_hi: got wr=%b rd=%b a=%h d=%h sel=%0d rdy=%b want wr=1 rd=0 a=fffd d=be sel=2 rdy=0", mem_wr, mem_rd, mem_addr, mem_wdata, sp_sel, req_ready); end
    tick();
    checks++; if ({mem_wr, mem_addr, mem_wdata, rsp_valid} !== {1'b1, 16'hFFFC, 8'hEF, 1'b0}) begin
      errors++; $display("FAIL push_lo: got wr=%b a=%h d=%h rv=%b want wr=1 a=fffc d=ef rv=0", mem_wr, mem_addr, mem_wdata, rsp_valid); end
    tick();
    checks++; if ({rsp_valid, mem_wr, req_ready} !== 3'b101) begin errors++; $display("FAIL push_rsp: got %b want 101", {rsp_valid, mem_wr, req_ready}); end
    checks++; if (sp !== 16'hFFFC) begin errors++; $display("FAIL push_sp: got %h want fffc", sp); end
    checks++; if ({mem[16'hFFFD], mem[16'hFFFC]} !== 16'hBEEF) begin errors++; $display("FAIL push_mem: got %h want beef", {mem[16'hFFFD], mem[16'hFFFC]}); end
    checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL push_wr_count: got %0d want 2", wr_cnt - w0); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL push_rsp_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_pop_basic;
    req_valid = 1'b1; req_pop = 1'b1;
    #1;
    checks++; if (sp_sel !== 3'd0) begin errors++; $display("FAIL pop_accept_sel: got %0d want 0", sp_sel); end
    tick();
    req_valid = 1'b0;
    checks++; if ({mem_rd, mem_wr, mem_addr, sp_sel} !== {2'b10, 16'hFFFC, 3'd1}) begin
      errors++; $display("FAIL pop_lo: got rd=%b wr=%b a=%h sel=%0d want rd=1 wr=0 a=fffc sel=1", mem_rd, mem_wr, mem_addr, sp_sel); end
    tick();
    checks++; if ({mem_rd, mem_addr, sp_sel} !== {1'b1, 16'hFFFD, 3'd1}) begin
      errors++; $display("FAIL pop_hi: got rd=%b a=%h sel=%0d want rd=1 a=fffd sel=1", mem_rd, mem_addr, sp_sel); end
    tick();
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL pop_rsp: got v=%b d=%h want v=1 d=beef", rsp_valid, rsp_data); end
    checks++; if (sp !== 16'hFFFE) begin errors++; $display("FAIL pop_sp: got %h want fffe", sp); end
    tick();
    checks++; if ({rsp_valid, rsp_data} !== {1'b0, 16'hBEEF}) begin errors++; $display("FAIL pop_hold: got v=%b d=%h want v=0 d=beef", rsp_valid, rsp_data); end
  endtask

  task automatic test_wait_states;
    logic exp_rdy;
    load_sp(16'h2000);
    mem_ready = 1'b0;
    req_valid = 1'b1; req_pop = 1'b0; req_data = 16'h1234;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      exp_rdy = (c == 4 || c == 8);
      mem_ready = exp_rdy;
      #1;
      checks++;
      if ({mem_wr, mem_rd, mem_addr, mem_wdata, rsp_valid} !==
          {2'b10, (c <= 4) ? 16'h1FFF : 16'h1FFE, (c <= 4) ? 8'h12 : 8'h34, 1'b0} ||
          sp_sel !== ((exp_rdy && c == 4) ? 3'd2 : 3'd0)) begin
        errors++; $display("FAIL wait_cycle%0d: got wr=%b a=%h d=%h sel=%0d rv=%b", c, mem_wr, mem_addr, mem_wdata, sp_sel, rsp_valid);
      end
      tick();
    end
    mem_ready = 1'b1;
    checks++; if ({rsp_valid, sp} !== {1'b1, 16'h1FFE}) begin errors++; $display("FAIL wait_rsp: got v=%b sp=%h want v=1 sp=1ffe", rsp_valid, sp); end
    checks++; if ({mem[16'h1FFF], mem[16'h1FFE]} !== 16'h1234) begin errors++; $display("FAIL wait_mem: got %h want 1234", {mem[16'h1FFF], mem[16'h1FFE]}); end
    tick();
  endtask

  task automatic test_back_to_back;
    load_sp(16'h5000);
    req_valid = 1'b1; req_pop = 1'b0; req_data = 16'hCAFE;
    tick(); req_valid = 1'b0;
    tick(); tick();
    // rsp_valid cycle: issue a POP immediately
    req_valid = 1'b1; req_pop = 1'b1;
    #1;
    checks++; if ({rsp_valid, req_ready} !== 2'b11) begin errors++; $display("FAIL b2b_ready: got %b want 11", {rsp_valid, req_ready}); end
    tick(); req_valid = 1'b0;
    checks++; if ({mem_rd, mem_addr} !== {1'b1, 16'h4FFE}) begin errors++; $display("FAIL b2b_pop_start: got rd=%b a=%h want rd=1 a=4ffe", mem_rd, mem_addr); end
    tick(); tick();
    checks++; if ({rsp_valid, rsp_data, sp} !== {1'b1, 16'hCAFE, 16'h5000}) begin errors++; $display("FAIL b2b_pop_rsp: got v=%b d=%h sp=%h want v=1 d=cafe sp=5000", rsp_valid, rsp_data, sp); end
    tick();
  endtask

`ifdef STACK_SEQ_BOUNDS_EN
  task automatic test_bounds;
    int w0;
    load_sp(16'hC001);
    w0 = wr_cnt;
    req_valid = 1'b1; req_pop = 1'b0; req_data = 16'h9999;
    #1;
    checks++; if (sp_sel !== 3'd0) begin errors++; $display("FAIL bounds_sel: got %0d want 0", sp_sel); end
    tick(); req_valid = 1'b0;
    checks++; if ({stack_fault, mem_wr, req_ready} !== 3'b101) begin errors++; $display("FAIL bounds_fault: got %b want 101", {stack_fault, mem_wr, req_ready}); end
    tick();
    checks++; if ({stack_fault, rsp_valid, sp} !== {2'b00, 16'hC001}) begin errors++; $display("FAIL bounds_after: got f=%b v=%b sp=%h want 0 0 c001", stack_fault, rsp_valid, sp); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL bounds_no_write: got %0d want %0d", wr_cnt, w0); end
    load_sp(16'hFFFD);
    req_valid = 1'b1; req_pop = 1'b1;
    tick(); req_valid = 1'b0;
    checks++; if ({stack_fault, mem_rd} !== 2'b10) begin errors++; $display("FAIL bounds_pop: got %b want 10", {stack_fault, mem_rd}); end
    tick();
  endtask
`else
  task automatic test_wrap;
    load_sp(16'h0001);
    req_valid = 1'b1; req_pop = 1'b0; req_data = 16'hA55A;
    tick(); req_valid = 1'b0;
    checks++; if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'h0000, 8'hA5}) begin errors++; $display("FAIL wrap_hi: got wr=%b a=%h d=%h want 1 0000 a5", mem_wr, mem_addr, mem_wdata); end
    tick();
    checks++; if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'hFFFF, 8'h5A}) begin errors++; $display("FAIL wrap_lo: got wr=%b a=%h d=%h want 1 ffff 5a", mem_wr, mem_addr, mem_wdata); end
    tick();
    checks++; if ({rsp_valid, stack_fault, sp} !== {2'b10, 16'hFFFF}) begin errors++; $display("FAIL wrap_done: got v=%b f=%b sp=%h want 1 0 ffff", rsp_valid, stack_fault, sp); end
    checks++; if ({mem[16'h0000], mem[16'hFFFF]} !== 16'hA55A) begin errors++; $display("FAIL wrap_mem: got %h want a55a", {mem[16'h0000], mem[16'hFFFF]}); end
    tick();
  endtask
`endif

  task automatic test_reset_mid;
    int w0;
    load_sp(16'h3000);
    w0 = wr_cnt;
    req_valid = 1'b1; req_pop = 1'b0; req_data = 16'h7766;
    tick(); req_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    checks++; if ({mem_wr, mem_rd, req_ready, rsp_valid, rsp_data} !== {4'b0010, 16'h0}) begin
      errors++; $display("FAIL rstmid_outputs: got wr=%b rd=%b rdy=%b v=%b d=%h want 0 0 1 0 0000", mem_wr, mem_rd, req_ready, rsp_valid, rsp_data); end
    tick(); tick();
    reset = 1'b1; mem_ready = 1'b1;
    tick();
    checks++; if ({rsp_valid, req_ready, mem_wr} !== 3'b010) begin errors++; $display("FAIL rstmid_idle: got %b want 010", {rsp_valid, req_ready, mem_wr}); end
    checks++; if ({wr_cnt - w0, 8'(mem[16'h2FFF])} !== {32'd1, 8'h77}) begin errors++; $display("FAIL rstmid_partial: got n=%0d b=%h want n=1 b=77", wr_cnt - w0, mem[16'h2FFF]); end
    load_sp(16'hFFFC);
    req_valid = 1'b1; req_pop = 1'b1;
    tick(); req_valid = 1'b0;
    checks++; if ({mem_rd, mem_addr} !== {1'b1, 16'hFFFC}) begin errors++; $display("FAIL rstmid_pop_start: got rd=%b a=%h want 1 fffc", mem_rd, mem_addr); end
    tick(); tick();
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL rstmid_pop_rsp: got v=%b d=%h want 1 beef", rsp_valid, rsp_data); end
    tick();
  endtask

  initial begin
    sp_load = 1'b1; sp_load_val = 16'h0000;
    test_reset();
    sp_load = 1'b0;
    test_push_basic();
    test_pop_basic();
    test_wait_states();
    test_back_to_back();
`ifdef STACK_SEQ_BOUNDS_EN
    test_bounds();
`else
    test_wrap();
`endif
    test_reset_mid();
    checks++; if (rdwr_viol !== 0) begin errors++; $display("FAIL rd_wr_exclusive: got %0d want 0", rdwr_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
